// File: rtl/sprite_mover_if.sv
// Video-side signal bundle for sprite_mover: pixel counters and buttons in,
// registered RGB, state and end-of-frame pulse out.
interface sprite_mover_if;
  logic [9:0] xsync;
  logic [9:0] ysync;
  logic [3:0] btn;
  logic [3:0] r_o;
  logic [3:0] g_o;
  logic [3:0] b_o;
  logic [1:0] state_o;
  logic       frame_tick_o;

  modport master (
    output xsync, ysync, btn,
    input  r_o, g_o, b_o, state_o, frame_tick_o
  );

  modport slave (
    input  xsync, ysync, btn,
    output r_o, g_o, b_o, state_o, frame_tick_o
  );
endinterface

// File: rtl/sprite_mover.sv
// Single square player sprite on a black 640x480 field, moved by debounced buttons
// once per frame. Define SPRITE_BORDER_EN for a blue 2-pixel frame with tighter bounds.
module sprite_mover #(
  parameter int SPRITE_SIZE  = 16,
  parameter int STEP         = 2,
  parameter int DEB_CYCLES   = 250000,
  parameter int FLASH_FRAMES = 30
) (
  input logic            clk,
  input logic            clr_n,
  sprite_mover_if.slave  vid
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLASH = 2'd2} state_t;

  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int FLASH_W = ($clog2(FLASH_FRAMES) > 3) ? $clog2(FLASH_FRAMES) : 3;
`ifdef SPRITE_BORDER_EN
  localparam int MIN_POS = 2;
  localparam int MAX_X   = 638 - SPRITE_SIZE;
  localparam int MAX_Y   = 478 - SPRITE_SIZE;
`else
  localparam int MIN_POS = 0;
  localparam int MAX_X   = 640 - SPRITE_SIZE;
  localparam int MAX_Y   = 480 - SPRITE_SIZE;
`endif
  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] MIN_S   = 11'(MIN_POS);
  localparam logic signed [10:0] MAX_X_S = 11'(MAX_X);
  localparam logic signed [10:0] MAX_Y_S = 11'(MAX_Y);

  logic [3:0]       sync_q1, sync_q2, deb;
  logic [DEB_W-1:0] deb_cnt [4];
  logic             frame_tick;

  // Buttons are asynchronous: two flops before anything looks at them.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q1    <= '0;
      sync_q2    <= '0;
      deb        <= '0;
      frame_tick <= 1'b0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync_q1    <= vid.btn;
      sync_q2    <= sync_q1;
      frame_tick <= (vid.xsync == 10'd799) && (vid.ysync == 10'd524);
      for (int i = 0; i < 4; i++) begin
        if (sync_q2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync_q2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t             state_q, state_d;
  logic [9:0]         pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [FLASH_W-1:0] flash_q, flash_d;
  logic signed [10:0] dx, dy, req_x, req_y, mov_x, mov_y;
  logic               clamp_x, clamp_y;

  // Signed 11-bit request so a step below zero is seen as negative, not wrapped.
  // NOTE: each always_comb assigns every output a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    dx = '0;
    dy = '0;
    if (deb[3] && !deb[2]) dx = STEP_S;
    else if (deb[2] && !deb[3]) dx = -STEP_S;
    if (deb[1] && !deb[0]) dy = STEP_S;
    else if (deb[0] && !deb[1]) dy = -STEP_S;
    req_x   = $signed({1'b0, pos_x_q}) + dx;
    req_y   = $signed({1'b0, pos_y_q}) + dy;
    mov_x   = req_x;
    mov_y   = req_y;
    clamp_x = 1'b0;
    clamp_y = 1'b0;
    if (req_x < MIN_S)        begin mov_x = MIN_S;   clamp_x = 1'b1; end
    else if (req_x > MAX_X_S) begin mov_x = MAX_X_S; clamp_x = 1'b1; end
    if (req_y < MIN_S)        begin mov_y = MIN_S;   clamp_y = 1'b1; end
    else if (req_y > MAX_Y_S) begin mov_y = MAX_Y_S; clamp_y = 1'b1; end
  end

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    flash_d = flash_q;
    if (frame_tick) begin
      unique case (state_q)
        IDLE: if (|deb) begin
          state_d = RUN;
          pos_x_d = mov_x[9:0];
          pos_y_d = mov_y[9:0];
        end
        RUN: begin
          pos_x_d = mov_x[9:0];
          pos_y_d = mov_y[9:0];
          if (clamp_x || clamp_y) begin
            state_d = FLASH;
            flash_d = '0;
          end
        end
        FLASH: begin
          if (flash_q == FLASH_W'(FLASH_FRAMES - 1)) begin
            state_d = RUN;
            flash_d = '0;
          end else begin
            flash_d = flash_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      pos_x_q <= 10'((640 - SPRITE_SIZE) / 2);
      pos_y_q <= 10'((480 - SPRITE_SIZE) / 2);
      flash_q <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      flash_q <= flash_d;
    end
  end

  logic [9:0]  hx, vy;
  logic        active, in_sprite;
  logic [11:0] sprite_rgb, pix_d, pix_q;

  always_comb begin
    hx     = vid.xsync - 10'd144;
    vy     = vid.ysync - 10'd35;
    active = (vid.xsync >= 10'd144) && (vid.xsync <= 10'd783) &&
             (vid.ysync >= 10'd35)  && (vid.ysync <= 10'd514);
    in_sprite = ({1'b0, hx} >= {1'b0, pos_x_q}) &&
                ({1'b0, hx} <  {1'b0, pos_x_q} + 11'(SPRITE_SIZE)) &&
                ({1'b0, vy} >= {1'b0, pos_y_q}) &&
                ({1'b0, vy} <  {1'b0, pos_y_q} + 11'(SPRITE_SIZE));
    unique case (state_q)
      IDLE:    sprite_rgb = 12'h0F0;
      RUN:     sprite_rgb = 12'hFFF;
      FLASH:   sprite_rgb = flash_q[2] ? 12'h000 : 12'hF00;
      default: sprite_rgb = 12'h000;
    endcase
    pix_d = 12'h000;
    if (active) begin
      if (in_sprite) pix_d = sprite_rgb;
`ifdef SPRITE_BORDER_EN
      else if ((hx < 10'd2) || (hx > 10'd637) || (vy < 10'd2) || (vy > 10'd477))
        pix_d = 12'h00F;
`endif
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) pix_q <= '0;
    else        pix_q <= pix_d;
  end

  assign vid.r_o          = pix_q[11:8];
  assign vid.g_o          = pix_q[7:4];
  assign vid.b_o          = pix_q[3:0];
  assign vid.state_o      = state_q;
  assign vid.frame_tick_o = frame_tick;

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover: directed vector table, hand-written
// edge-hit/flash and reset sequences, then random button runs against a frame-level model.
module tb_sprite_mover;

  localparam int SIZE   = 16;
  localparam int STEP   = 2;
  localparam int DEB    = 4;
  localparam int FLASHN = 30;
`ifdef SPRITE_BORDER_EN
  localparam int MIN_B = 2;
  localparam int MAX_X = 638 - SIZE;
  localparam int MAX_Y = 478 - SIZE;
`else
  localparam int MIN_B = 0;
  localparam int MAX_X = 640 - SIZE;
  localparam int MAX_Y = 480 - SIZE;
`endif
  localparam logic [11:0] GREEN = 12'h0F0, WHITE = 12'hFFF, RED = 12'hF00;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #20 clk = ~clk;

  sprite_mover_if vid();

  sprite_mover #(
    .SPRITE_SIZE(SIZE), .STEP(STEP), .DEB_CYCLES(DEB), .FLASH_FRAMES(FLASHN)
  ) dut (
    .clk(clk), .clr_n(clr_n), .vid(vid)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference model: position, state, flash count, debounced buttons.
  int         mpx, mpy, mflash;
  int         mstate;
  logic [3:0] mdeb;

  task automatic model_reset();
    mpx = (640 - SIZE) / 2; mpy = (480 - SIZE) / 2;
    mstate = 0; mflash = 0; mdeb = 4'b0;
  endtask

  task automatic model_move(output bit hit);
    int nx, ny;
    hit = 0;
    nx = mpx + (int'(mdeb[3]) - int'(mdeb[2])) * STEP;
    ny = mpy + (int'(mdeb[1]) - int'(mdeb[0])) * STEP;
    if (nx < MIN_B) begin nx = MIN_B; hit = 1; end
    if (nx > MAX_X) begin nx = MAX_X; hit = 1; end
    if (ny < MIN_B) begin ny = MIN_B; hit = 1; end
    if (ny > MAX_Y) begin ny = MAX_Y; hit = 1; end
    mpx = nx; mpy = ny;
  endtask

  task automatic model_tick();
    bit hit;
    case (mstate)
      0: if (mdeb != 0) begin model_move(hit); mstate = 1; end
      1: begin model_move(hit); if (hit) begin mstate = 2; mflash = 0; end end
      default: if (mflash == FLASHN - 1) begin mstate = 1; mflash = 0; end
               else mflash++;
    endcase
  endtask

  function automatic logic [11:0] model_colour();
    case (mstate)
      0: return GREEN;
      1: return WHITE;
      default: return ((mflash >> 2) & 1) ? 12'h000 : RED;
    endcase
  endfunction

  // Expected non-sprite pixel at absolute counter coordinates.
  function automatic logic [11:0] bg_pixel(input int x, input int y);
    if (x < 144 || x > 783 || y < 35 || y > 514) return 12'h000;
`ifdef SPRITE_BORDER_EN
    if (x - 144 < 2 || x - 144 > 637 || y - 35 < 2 || y - 35 > 477) return 12'h00F;
`endif
    return 12'h000;
  endfunction

  task automatic probe(input int x, input int y, output logic [11:0] pix);
    @(negedge clk);
    vid.xsync = 10'(x);
    vid.ysync = 10'(y);
    @(negedge clk);
    pix = {vid.r_o, vid.g_o, vid.b_o};
  endtask

  task automatic do_frame();
    @(negedge clk);
    vid.xsync = 10'd799; vid.ysync = 10'd524;
    @(negedge clk);
    vid.xsync = 10'd0; vid.ysync = 10'd0;
    @(negedge clk);
    model_tick();
  endtask

  task automatic set_btn(input logic [3:0] b);
    @(negedge clk);
    vid.btn = b; vid.xsync = 10'd0; vid.ysync = 10'd0;
    repeat (10) @(negedge clk);
    mdeb = b;
  endtask

  // Corner pixels inside the sprite, neighbours just outside it on the left and right.
  task automatic check_pos(input string name, input int px, input int py, input logic [11:0] col);
    logic [11:0] p;
    probe(144 + px, 35 + py, p);
    check({name, " top-left"}, 32'(p), 32'(col));
    probe(144 + px + SIZE - 1, 35 + py + SIZE - 1, p);
    check({name, " bottom-right"}, 32'(p), 32'(col));
    probe(144 + px - 1, 35 + py, p);
    check({name, " left-outside"}, 32'(p), 32'(bg_pixel(144 + px - 1, 35 + py)));
    probe(144 + px + SIZE, 35 + py, p);
    check({name, " right-outside"}, 32'(p), 32'(bg_pixel(144 + px + SIZE, 35 + py)));
  endtask

  typedef struct {
    logic [3:0] btn;
    int         frames;
    logic [1:0] st;
    int         px;
    int         py;
  } vec_t;
  vec_t vecs [6];

  initial begin
    logic [11:0] p;
    int n;

    vecs[0] = '{4'b1000, 10, 2'd1, 332, 232};
    vecs[1] = '{4'b1100,  3, 2'd1, 332, 232};
    vecs[2] = '{4'b0011,  3, 2'd1, 332, 232};
    vecs[3] = '{4'b0001,  5, 2'd1, 332, 222};
    vecs[4] = '{4'b0110,  4, 2'd1, 324, 230};
    vecs[5] = '{4'b0000,  2, 2'd1, 324, 230};

    vid.xsync = 10'd0; vid.ysync = 10'd0; vid.btn = 4'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset rgb", 32'({vid.r_o, vid.g_o, vid.b_o}), 32'h0);
    check("reset state", 32'(vid.state_o), 32'd0);
    check("reset tick", 32'(vid.frame_tick_o), 32'd0);
    clr_n = 1'b1;

    check_pos("idle sprite", 312, 232, GREEN);
    probe(100, 100, p);
    check("blanking pixel", 32'(p), 32'h0);

    // frame_tick only on the last counter position of the frame
    @(negedge clk); vid.xsync = 10'd799; vid.ysync = 10'd0;
    @(negedge clk);
    check("no tick mid-frame", 32'(vid.frame_tick_o), 32'd0);
    vid.xsync = 10'd799; vid.ysync = 10'd524;
    @(negedge clk);
    check("tick at end of frame", 32'(vid.frame_tick_o), 32'd1);
    vid.xsync = 10'd0; vid.ysync = 10'd0;
    @(negedge clk);
    check("tick one cycle", 32'(vid.frame_tick_o), 32'd0);
    model_tick();

    // glitch shorter than the debounce window must not register
    @(negedge clk); vid.btn = 4'b0001;
    repeat (2) @(negedge clk);
    vid.btn = 4'b0000;
    repeat (8) @(negedge clk);
    repeat (3) do_frame();
    check("glitch state", 32'(vid.state_o), 32'd0);
    check_pos("glitch pos", 312, 232, GREEN);

    for (int i = 0; i < 6; i++) begin
      set_btn(vecs[i].btn);
      repeat (vecs[i].frames) do_frame();
      check($sformatf("vec%0d state", i), 32'(vid.state_o), 32'(vecs[i].st));
      check_pos($sformatf("vec%0d pos", i), vecs[i].px, vecs[i].py, WHITE);
    end

    // Walk left onto the bound, push once more, then ride out the flash.
    set_btn(4'b0100);
    n = (324 - MIN_B) / STEP;
    repeat (n) do_frame();
    check("at left bound state", 32'(vid.state_o), 32'd1);
    check_pos("at left bound", MIN_B, 230, WHITE);
    do_frame();
    check("edge hit state", 32'(vid.state_o), 32'd2);
    check_pos("flash start", MIN_B, 230, RED);
    for (int k = 1; k < FLASHN; k++) begin
      do_frame();
      check($sformatf("flash%0d state", k), 32'(vid.state_o), 32'd2);
      probe(144 + MIN_B + 3, 35 + 233, p);
      check($sformatf("flash%0d colour", k), 32'(p), ((k >> 2) & 1) ? 32'h0 : 32'(RED));
    end
    do_frame();
    check("flash exit state", 32'(vid.state_o), 32'd1);
    check_pos("flash exit pos", MIN_B, 230, WHITE);
    set_btn(4'b0000);

    for (int it = 0; it < 40; it++) begin
      set_btn(4'($urandom_range(0, 15)));
      repeat ($urandom_range(1, 60)) do_frame();
      check($sformatf("rand%0d state", it), 32'(vid.state_o), 32'(mstate));
      check_pos($sformatf("rand%0d pos", it), mpx, mpy, model_colour());
    end

    // Asynchronous reset mid-line, away from any clock edge.
    set_btn(4'b0000);
    probe(144 + mpx, 35 + mpy, p);
    @(negedge clk);
    #2 vid.xsync = 10'd400; clr_n = 1'b0;
    #1;
    check("async reset rgb", 32'({vid.r_o, vid.g_o, vid.b_o}), 32'h0);
    check("async reset state", 32'(vid.state_o), 32'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    model_reset();
    check_pos("post reset pos", 312, 232, GREEN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
